// File: rtl/acondicionador_entradas_pkg.sv
// Shared types and default constants for the input-conditioning stage
// (acondicionador_entradas and its per-channel debouncer).
package acondicionador_pkg;

    typedef enum logic {
        ESTABLE     = 1'b0,
        VERIFICANDO = 1'b1
    } estado_canal_t;

    localparam int SYNC_STAGES_DEF     = 2;
    localparam int DEBOUNCE_CYCLES_DEF = 50000;
    localparam int CNT_W_DEF           = 16;

endpackage

// File: rtl/acondicionador_entradas_if.sv
// Signal bundle between the raw-input side and the sequence FSM. The edge-pulse
// signals exist only when ACONDICIONADOR_FLANCOS_EN is defined.
interface acondicionador_entradas_if;

    logic       a_raw;
    logic       b_raw;
    logic       A;
    logic       B;
    logic       cambio;
    logic [1:0] estado_depurado;
`ifdef ACONDICIONADOR_FLANCOS_EN
    logic       a_flanco;
    logic       b_flanco;
`endif

`ifdef ACONDICIONADOR_FLANCOS_EN
    modport master (output a_raw, b_raw,
                    input  A, B, cambio, estado_depurado, a_flanco, b_flanco);
    modport slave  (input  a_raw, b_raw,
                    output A, B, cambio, estado_depurado, a_flanco, b_flanco);
`else
    modport master (output a_raw, b_raw,
                    input  A, B, cambio, estado_depurado);
    modport slave  (input  a_raw, b_raw,
                    output A, B, cambio, estado_depurado);
`endif

endinterface

// File: rtl/acondicionador_entradas_antirrebote_canal.sv
// One debounced channel: SYNC_STAGES-flop synchronizer, restartable stability
// counter and two-state FSM. cambio_prox flags that out_q changes on the next edge.
module antirrebote_canal
    import acondicionador_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          raw,
    output logic          out,
    output logic          cambio_prox,
    output estado_canal_t estado
);

    localparam logic [CNT_W-1:0] LIMITE = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] UNO    = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   out_q, out_d;
    estado_canal_t          estado_q, estado_d;
    logic                   s_x;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], raw};
    assign s_x    = sync_q[SYNC_STAGES-1];

    always_comb begin
        estado_d    = estado_q;
        cnt_d       = '0;
        out_d       = out_q;
        cambio_prox = 1'b0;
        case (estado_q)
            ESTABLE: begin
                if (s_x != out_q) begin
                    estado_d = VERIFICANDO;
                    cnt_d    = UNO;
                end
            end
            VERIFICANDO: begin
                // A bounce back drops the partial count entirely.
                if (s_x == out_q) begin
                    estado_d = ESTABLE;
                end else if (cnt_q == LIMITE) begin
                    out_d       = s_x;
                    estado_d    = ESTABLE;
                    cambio_prox = 1'b1;
                end else begin
                    cnt_d = cnt_q + UNO;
                end
            end
            default: estado_d = ESTABLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            out_q    <= 1'b0;
            estado_q <= ESTABLE;
        end else begin
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            out_q    <= out_d;
            estado_q <= estado_d;
        end
    end

    assign out    = out_q;
    assign estado = estado_q;

endmodule

// File: rtl/acondicionador_entradas.sv
// Two-channel input conditioner feeding the sequence FSM's A/B inputs.
// Optional macro ACONDICIONADOR_FLANCOS_EN adds registered rising-edge pulses.
module acondicionador_entradas
    import acondicionador_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    acondicionador_entradas_if.slave bus
);

    logic          a_out, b_out;
    logic          a_chg, b_chg;
    estado_canal_t a_estado, b_estado;
    logic          cambio_q, cambio_d;

    antirrebote_canal #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_canal_a (
        .clk         (clk),
        .rst         (rst),
        .raw         (bus.a_raw),
        .out         (a_out),
        .cambio_prox (a_chg),
        .estado      (a_estado)
    );

    antirrebote_canal #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_canal_b (
        .clk         (clk),
        .rst         (rst),
        .raw         (bus.b_raw),
        .out         (b_out),
        .cambio_prox (b_chg),
        .estado      (b_estado)
    );

    // Registered here so the pulse lines up with the edge where A/B update.
    assign cambio_d = a_chg | b_chg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cambio_q <= 1'b0;
        end else begin
            cambio_q <= cambio_d;
        end
    end

`ifdef ACONDICIONADOR_FLANCOS_EN
    logic a_flanco_q, a_flanco_d;
    logic b_flanco_q, b_flanco_d;

    // A change while the output is low can only be a rise.
    assign a_flanco_d = a_chg & ~a_out;
    assign b_flanco_d = b_chg & ~b_out;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_flanco_q <= 1'b0;
            b_flanco_q <= 1'b0;
        end else begin
            a_flanco_q <= a_flanco_d;
            b_flanco_q <= b_flanco_d;
        end
    end

    assign bus.a_flanco = a_flanco_q;
    assign bus.b_flanco = b_flanco_q;
`endif

    assign bus.A               = a_out;
    assign bus.B               = b_out;
    assign bus.cambio          = cambio_q;
    assign bus.estado_depurado = {b_estado, a_estado};

endmodule
